// File: rtl/set_cmd_queue.sv
// ---------------------------------------------------------------------------
// set_cmd_queue
//
// Command queue and dispatcher in front of the SET circle-set counter. Host
// jobs (packed centres, radii, mode) are buffered in a circular FIFO and
// handed to SET one at a time: a job is popped into the output registers,
// announced with a one-cycle 'en' strobe, then held open until SET pulses
// 'valid'. Completed jobs are counted and dropped pushes raise a sticky flag.
//
// Optional feature macro: SET_CMD_WDOG_EN
//   Defined   : a watchdog limits the wait for 'valid' to TIMEOUT cycles; on
//               expiry 'wdog_err' is set and the dispatcher moves on.
//   Undefined : the dispatcher waits for 'valid' indefinitely and
//               'wdog_err' is constant 0.
//
// Parameters:
//   DEPTH    queue entries (power of two, >= 2)
//   AW       log2(DEPTH)
//   TIMEOUT  watchdog limit in cycles (only with SET_CMD_WDOG_EN)
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   push              host write strobe
//   push_central      {xA,yA,xB,yB,xC,yC}, 4 bits each
//   push_radius       {rA,rB,rC}, 4 bits each
//   push_mode         job mode, passed through unchanged
//   full, empty       registered queue status
//   level             number of stored entries
//   overflow          sticky: a push was dropped because the queue was full
//   en                one-cycle job strobe to SET
//   central/radius/mode  current job, stable from issue until the next pop
//   busy, valid       handshake from SET
//   done_cnt          completed job count, wraps at 16 bits
//   wdog_err          sticky watchdog expiry flag
// ---------------------------------------------------------------------------
module set_cmd_queue #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [23:0]   push_central,
    input  logic [11:0]   push_radius,
    input  logic [1:0]    push_mode,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          en,
    output logic [23:0]   central,
    output logic [11:0]   radius,
    output logic [1:0]    mode,
    input  logic          busy,
    input  logic          valid,
    output logic [15:0]   done_cnt,
    output logic          wdog_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    // Entry layout: {mode, radius, central}
    logic [37:0]   mem [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    state_q, state_d;
    logic [23:0]   central_q, central_d;
    logic [11:0]   radius_q, radius_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   doneCnt_q, doneCnt_d;

    logic          doPush;
    logic          doPop;
    logic          wdExpire;

    // Full is judged on the pre-edge registered status, so a push into a
    // full queue is dropped even if a pop happens on the same edge.
    assign doPush = push & ~full_q;
    assign doPop  = (state_q == IDLE) & ~empty_q & ~busy;

    // Storage array is deliberately left out of reset; pointers define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= {push_mode, push_radius, push_central};
        end
    end

    // Queue bookkeeping: pointers wrap naturally because DEPTH is 2**AW.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (push & full_q);
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == (AW+1)'(DEPTH));
        empty_d = (level_d == '0);
    end

    // Dispatcher: IDLE pops into the output registers, ISSUE strobes en for
    // one cycle, WAIT holds until SET reports completion (or the watchdog
    // gives up). Valid outside WAIT is ignored.
    always_comb begin
        state_d   = state_q;
        central_d = central_q;
        radius_d  = radius_q;
        mode_d    = mode_q;
        doneCnt_d = doneCnt_q;
        case (state_q)
            IDLE: begin
                if (doPop) begin
                    {mode_d, radius_d, central_d} = mem[rdPtr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (valid) begin
                    state_d   = IDLE;
                    doneCnt_d = doneCnt_q + 16'd1;
                end else if (wdExpire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            central_q  <= '0;
            radius_q   <= '0;
            mode_q     <= '0;
            doneCnt_q  <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            central_q  <= central_d;
            radius_q   <= radius_d;
            mode_q     <= mode_d;
            doneCnt_q  <= doneCnt_d;
        end
    end

`ifdef SET_CMD_WDOG_EN
    // Counter width only needs to hold TIMEOUT-1: expiry fires on the
    // TIMEOUT-th consecutive WAIT cycle without valid.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WW-1:0] wdCnt_q, wdCnt_d;
    logic          wdogErr_q, wdogErr_d;

    always_comb begin
        wdExpire  = (state_q == WAIT) & ~valid & (wdCnt_q == WW'(TIMEOUT - 1));
        wdogErr_d = wdogErr_q | wdExpire;
        if ((state_q == WAIT) && !valid && !wdExpire) begin
            wdCnt_d = wdCnt_q + 1'b1;
        end else begin
            wdCnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCnt_q   <= '0;
            wdogErr_q <= 1'b0;
        end else begin
            wdCnt_q   <= wdCnt_d;
            wdogErr_q <= wdogErr_d;
        end
    end

    assign wdog_err = wdogErr_q;
`else
    assign wdExpire = 1'b0;
    assign wdog_err = 1'b0;
`endif

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign en       = (state_q == ISSUE);
    assign central  = central_q;
    assign radius   = radius_q;
    assign mode     = mode_q;
    assign done_cnt = doneCnt_q;

endmodule

// File: tb/tb_set_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_set_cmd_queue
//
// Self-checking bench for set_cmd_queue. A table of per-cycle vectors covers
// the basic issue/complete flow; hand-written sequences cover overflow,
// busy gating with back-to-back completions, reset mid-job and (when
// SET_CMD_WDOG_EN is defined) the watchdog with TIMEOUT = 15.
// ---------------------------------------------------------------------------
module tb_set_cmd_queue;

    logic        clk;
    logic        rst;
    logic        push;
    logic [23:0] pushCentral;
    logic [11:0] pushRadius;
    logic [1:0]  pushMode;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        overflow;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [15:0] doneCnt;
    logic        wdogErr;

    int checkCount;
    int passCount;

    set_cmd_queue #(.DEPTH(8), .AW(3), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_central (pushCentral),
        .push_radius  (pushRadius),
        .push_mode    (pushMode),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .en           (en),
        .central      (central),
        .radius       (radius),
        .mode         (mode),
        .busy         (busy),
        .valid        (valid),
        .done_cnt     (doneCnt),
        .wdog_err     (wdogErr)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        push;
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        logic        busy;
        logic        valid;
        logic        expEn;
        logic [3:0]  expLevel;
        logic        expEmpty;
        logic [15:0] expDone;
        logic [23:0] expCentral;
        logic [1:0]  expMode;
    } vec_t;

    vec_t vecs[15];

    // Single comparison with pass/fail bookkeeping
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector, advance one edge, sample 1 unit after it
    task automatic applyStimulus(input vec_t v);
        push        = v.push;
        pushCentral = v.c;
        pushRadius  = v.r;
        pushMode    = v.m;
        busy        = v.busy;
        valid       = v.valid;
        @(posedge clk);
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Async reset, checked before any clock edge sees it
    task automatic doReset();
        push  = 1'b0;
        busy  = 1'b0;
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstEmpty", 32'(empty), 32'd1);
        checkOutput("rstLevel", 32'(level), 32'd0);
        checkOutput("rstEn", 32'(en), 32'd0);
        checkOutput("rstDone", 32'(doneCnt), 32'd0);
        checkOutput("rstCentral", 32'(central), 32'd0);
        checkOutput("rstOverflow", 32'(overflow), 32'd0);
        checkOutput("rstWdog", 32'(wdogErr), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the job strobe
    task automatic waitEn();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (en) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("enTimeout", 32'(seen), 32'd1);
    endtask

    task automatic pushJob(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        push        = 1'b1;
        pushCentral = c;
        pushRadius  = r;
        pushMode    = m;
        @(posedge clk);
        #1;
        push = 1'b0;
    endtask

    initial begin
        int enCount;
        checkCount  = 0;
        passCount   = 0;
        rst         = 1'b0;
        push        = 1'b0;
        pushCentral = '0;
        pushRadius  = '0;
        pushMode    = '0;
        busy        = 1'b0;
        valid       = 1'b0;

        //             push c         r       m     busy valid  en lvl emp done  central    mode
        vecs[0]  = '{1'b1, 24'h440000, 12'h300, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 16'd0, 24'h000000, 2'd0};
        vecs[1]  = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 16'd0, 24'h440000, 2'd0};
        vecs[2]  = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'd0, 24'h440000, 2'd0};
        vecs[3]  = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'd1, 24'h440000, 2'd0};
        vecs[4]  = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'd1, 24'h440000, 2'd0};
        vecs[5]  = '{1'b1, 24'h123456, 12'hABC, 2'd2, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 16'd1, 24'h440000, 2'd0};
        vecs[6]  = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 16'd1, 24'h123456, 2'd2};
        vecs[7]  = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'd1, 24'h123456, 2'd2};
        vecs[8]  = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'd1, 24'h123456, 2'd2};
        vecs[9]  = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'd2, 24'h123456, 2'd2};
        vecs[10] = '{1'b1, 24'h0F0F0F, 12'h111, 2'd3, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 16'd2, 24'h123456, 2'd2};
        vecs[11] = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 16'd2, 24'h123456, 2'd2};
        vecs[12] = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 16'd2, 24'h0F0F0F, 2'd3};
        vecs[13] = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 16'd2, 24'h0F0F0F, 2'd3};
        vecs[14] = '{1'b0, 24'h000000, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'd3, 24'h0F0F0F, 2'd3};

        doReset();

        // Table-driven basic flow: latency, stray valid, busy gating
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d.en", i), 32'(en), 32'(vecs[i].expEn));
            checkOutput($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].expLevel));
            checkOutput($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].expEmpty));
            checkOutput($sformatf("vec%0d.done", i), 32'(doneCnt), 32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d.central", i), 32'(central), 32'(vecs[i].expCentral));
            checkOutput($sformatf("vec%0d.mode", i), 32'(mode), 32'(vecs[i].expMode));
        end
        push  = 1'b0;
        valid = 1'b0;
        checkOutput("vecRadius", 32'(radius), 32'h111);

        // Overflow: nine pushes while SET is busy, ninth is dropped
        doReset();
        busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pushJob(24'hA00000 | 24'(i), 12'h100 | 12'(i), 2'(i));
        end
        checkOutput("ovfLevel", 32'(level), 32'd8);
        checkOutput("ovfFull", 32'(full), 32'd1);
        checkOutput("ovfFlag", 32'(overflow), 32'd1);
        checkOutput("ovfEn", 32'(en), 32'd0);
        busy = 1'b0;
        for (int j = 0; j < 8; j++) begin
            waitEn();
            checkOutput($sformatf("ovfOrder%0d.central", j), 32'(central), 32'hA00000 | 32'(j));
            checkOutput($sformatf("ovfOrder%0d.radius", j), 32'(radius), 32'h100 | 32'(j));
            checkOutput($sformatf("ovfOrder%0d.level", j), 32'(level), 32'(7 - j));
            checkOutput($sformatf("ovfOrder%0d.full", j), 32'(full), 32'd0);
            stepCycle();
            valid = 1'b1;
            stepCycle();
            valid = 1'b0;
        end
        enCount = 0;
        for (int k = 0; k < 5; k++) begin
            if (en) enCount++;
            stepCycle();
        end
        checkOutput("ovfNoNinth", 32'(enCount), 32'd0);
        checkOutput("ovfDone", 32'(doneCnt), 32'd8);
        checkOutput("ovfEmpty", 32'(empty), 32'd1);
        checkOutput("ovfSticky", 32'(overflow), 32'd1);

        // Handshake gating: three jobs held back by busy, then drained
        doReset();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pushJob(24'hB00000 | 24'(i), 12'h200 | 12'(i), 2'd1);
        end
        enCount = 0;
        for (int k = 0; k < 20; k++) begin
            if (en) enCount++;
            stepCycle();
        end
        checkOutput("gateNoEn", 32'(enCount), 32'd0);
        checkOutput("gateLevel", 32'(level), 32'd3);
        busy = 1'b0;
        waitEn();
        checkOutput("gateFirst", 32'(central), 32'hB00000);
        for (int j = 0; j < 3; j++) begin
            stepCycle();
            valid = 1'b1;
            stepCycle();
            valid = 1'b0;
            checkOutput($sformatf("gateDone%0d", j), 32'(doneCnt), 32'(j + 1));
            stepCycle();
            // Next job strobes exactly one edge after completion
            checkOutput($sformatf("gateSpacing%0d", j), 32'(en), (j < 2) ? 32'd1 : 32'd0);
            if (j < 2) begin
                checkOutput($sformatf("gateOrder%0d", j + 1), 32'(central), 32'hB00000 | 32'(j + 1));
            end
        end
        checkOutput("gateDoneTotal", 32'(doneCnt), 32'd3);

        // Reset asserted while a job is outstanding in WAIT
        pushJob(24'hC0FFEE, 12'hDEF, 2'd3);
        waitEn();
        stepCycle();
        checkOutput("midWaitEn", 32'(en), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstEn", 32'(en), 32'd0);
        checkOutput("midRstDone", 32'(doneCnt), 32'd0);
        checkOutput("midRstCentral", 32'(central), 32'd0);
        checkOutput("midRstRadius", 32'(radius), 32'd0);
        checkOutput("midRstMode", 32'(mode), 32'd0);
        checkOutput("midRstEmpty", 32'(empty), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        stepCycle();
        checkOutput("postRstEn", 32'(en), 32'd0);

`ifdef SET_CMD_WDOG_EN
        // Watchdog: first job never completes, second must still issue
        doReset();
        pushJob(24'h111111, 12'h222, 2'd0);
        pushJob(24'h333333, 12'h444, 2'd1);
        waitEn();
        checkOutput("wdFirst", 32'(central), 32'h111111);
        for (int k = 0; k < 15; k++) begin
            stepCycle();
        end
        checkOutput("wdNotYet", 32'(wdogErr), 32'd0);
        stepCycle();
        checkOutput("wdErr", 32'(wdogErr), 32'd1);
        checkOutput("wdIdleEn", 32'(en), 32'd0);
        stepCycle();
        checkOutput("wdNextEn", 32'(en), 32'd1);
        checkOutput("wdNextCentral", 32'(central), 32'h333333);
        checkOutput("wdDone", 32'(doneCnt), 32'd0);
        checkOutput("wdSticky", 32'(wdogErr), 32'd1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/set_cmd_queue.md
# set_cmd_queue

Command queue and dispatcher that sits directly upstream of the `SET` circle-set counter. It buffers circle-set jobs from a host, each made of packed centres, radii and a mode. It issues them to `SET` one at a time over the `en`/`busy` handshake and holds each job open until `SET` pulses `valid`. It also keeps a completion count and a sticky overflow flag.

## Interface
- `DEPTH`, 8: queue entries; a power of two, minimum 2.
- `AW`, 3: log2(`DEPTH`).
- `TIMEOUT`, 1023: watchdog limit in cycles; used only under `SET_CMD_WDOG_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `push`  in  1  host write strobe, sampled on the rising edge.
- `push_central`  in  24  {xA,yA,xB,yB,xC,yC}, 4 bits each.
- `push_radius`  in  12  {rA,rB,rC}, 4 bits each.
- `push_mode`  in  2  0 = A, 1 = A∪B, 2 = A⊕B, 3 = A∩B∩C-style intersect mode, passed through unchanged.
- `full`  out  1  queue holds `DEPTH` entries.
- `empty`  out  1  queue holds 0 entries.
- `level`  out  AW+1  number of stored entries.
- `overflow`  out  1  sticky; a push was dropped.
- `en`  out  1  one-cycle job strobe to `SET`.
- `central`  out  24  job centres to `SET`.
- `radius`  out  12  job radii to `SET`.
- `mode`  out  2  job mode to `SET`.
- `busy`  in  1  from `SET`.
- `valid`  in  1  from `SET`; marks job completion.
- `done_cnt`  out  16  jobs completed; wraps from 0xFFFF to 0.
- `wdog_err`  out  1  sticky watchdog flag; tied to 0 when the macro is absent.

## Operation
- The FIFO is a circular buffer with AW-bit read and write pointers and a separate `level` counter.
- Write with `push`=1 and `full`=0: store the entry and advance the write pointer.
- Write with `push`=1 and `full`=1: drop the entry and set `overflow`. This holds even if a pop happens on the same edge, because `full` is judged from pre-edge state.
- Simultaneous push and pop with 0 < level < DEPTH: `level` is unchanged.
- FSM has three states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when `empty`=0 and `busy`=0. On that edge, pop the head entry into the `central`/`radius`/`mode` output registers.
  - ISSUE: `en`=1 for exactly this one cycle; always → WAIT.
  - WAIT: `en`=0. On `valid`=1, go → IDLE and increment `done_cnt`.
- `central`/`radius`/`mode` stay stable from ISSUE until the next pop.
- `valid` seen in IDLE or ISSUE is ignored and does not count.
- A job whose `busy` stays low in WAIT is not re-issued; the block waits for `valid` only.

## Timing
- Reset values, async on `rst`=1:
  - state = IDLE; pointers, `level`, `done_cnt` = 0.
  - `empty`=1; `full`=0, `overflow`=0, `wdog_err`=0.
  - `en`=0; `central`=0, `radius`=0, `mode`=0.
- FIFO contents are not reset.
- Latency: push sampled at edge t into an empty queue, FSM in IDLE, `busy`=0 → `en` high from edge t+1 to edge t+2.
- Minimum job spacing: `valid` at edge v → next `en` rises at edge v+1, given a non-empty queue and `busy`=0.
- `full`, `empty` and `level` are registered and update on the edge after a push or pop.
- Reset mid-job (any state) abandons the outstanding job. Queued entries are lost because the pointers clear.

## Configuration
- `SET_CMD_WDOG_EN` defined: a counter runs in WAIT and clears on leaving WAIT.
  - When it reaches `TIMEOUT` without `valid`: set `wdog_err`, force WAIT → IDLE, do not increment `done_cnt`.
  - Next job issues normally.
- Undefined: no counter; WAIT lasts indefinitely; `wdog_err` is constant 0.

## Test plan
- Reset check: after reset, `empty`=1, `level`=0, `en`=0, `done_cnt`=0, `central`=0.
- Single job: push central=0x4_4_0_0_0_0 (packed 0x440000), radius=0x300, mode=0 at edge t with model `busy`=0. Expect:
  - `en`=1 only in the cycle from edge t+1 to t+2, with `central`=0x440000 and `radius`=0x300.
  - Model `valid` pulse → `done_cnt`=1.
- Overflow: push 9 entries back-to-back while the model holds `busy`=1. Expect `level`=8, `full`=1, `overflow`=1, with entry 9 absent. Then release and confirm entries 0..7 issue in order.
- Handshake gating: queue 3 jobs with `busy`=1 held for 20 cycles. Expect no `en`. After `busy` falls, one `en` per `valid`, and `done_cnt`=3.
- Stray valid: pulse `valid` in IDLE → `done_cnt` unchanged. Reset asserted during WAIT → all outputs return to reset values within the same cycle.
- Watchdog, `SET_CMD_WDOG_EN` with `TIMEOUT`=15: issue one job and never pulse `valid`. Expect `wdog_err`=1 after 15 WAIT cycles, the FSM back in IDLE, the next queued job issued, and `done_cnt`=0.
